// File: rtl/gfx_ctrl_pkg.sv
// Shared types and defaults for the render-domain frame control path.
package gfx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CAM    = 3'd1,
        SETTLE = 3'd2,
        FEED   = 3'd3,
        DRAIN  = 3'd4,
        SWAP   = 3'd5
    } frame_seq_state_t;

    localparam int unsigned DEF_ANGLE_W    = 8;
    localparam int unsigned DEF_SINCOS_LAT = 2;

endpackage

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: camera pulse, angle step, feeder kick, drain wait, buffer swap.
// Optional FRAME_SEQ_STATS_EN adds saturating frames_done / frames_dropped counters.
module frame_sequencer
    import gfx_ctrl_pkg::*;
#(
    parameter int unsigned ANGLE_W    = DEF_ANGLE_W,
    parameter int unsigned SINCOS_LAT = DEF_SINCOS_LAT,
    parameter int unsigned BUSY_GRACE = 4,
    parameter int unsigned TIMEOUT    = 2000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [2:0]         rot_en,
    input  logic               feeder_busy,
    input  logic               renderer_busy,
    output logic               render_begin,
    output logic               cam_valid,
    output logic               feeder_begin,
    output logic               fb_swap,
    output logic [ANGLE_W-1:0] ang_x,
    output logic [ANGLE_W-1:0] ang_y,
    output logic [ANGLE_W-1:0] ang_z,
    output logic               seq_busy,
    output logic               timeout_flag
`ifdef FRAME_SEQ_STATS_EN
    ,
    output logic [15:0]        frames_done,
    output logic [15:0]        frames_dropped
`endif
);

    localparam int unsigned SET_W = $clog2(SINCOS_LAT + 1);
    localparam int unsigned GR_W  = $clog2(BUSY_GRACE + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    frame_seq_state_t  state, state_nx;
    logic [SET_W-1:0]  settle_cnt;
    logic [GR_W-1:0]   grace_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              busy_any;
    logic              accept;
    logic              forced;

    assign busy_any = feeder_busy | renderer_busy;
    assign seq_busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        forced   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start && !busy_any) begin
                    accept   = 1'b1;
                    state_nx = CAM;
                end
            end
            CAM:    state_nx = SETTLE;
            SETTLE: if (settle_cnt == SET_W'(SINCOS_LAT - 1)) state_nx = FEED;
            FEED:   state_nx = DRAIN;
            DRAIN: begin
                // a normal drain completion wins over a timeout in the same cycle
                if (grace_cnt == '0 && !busy_any) begin
                    state_nx = SWAP;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nx = SWAP;
                    forced   = 1'b1;
                end
            end
            SWAP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            render_begin <= 1'b0;
            cam_valid    <= 1'b0;
            feeder_begin <= 1'b0;
            fb_swap      <= 1'b0;
            ang_x        <= '0;
            ang_y        <= '0;
            ang_z        <= '0;
            timeout_flag <= 1'b0;
            settle_cnt   <= '0;
            grace_cnt    <= '0;
            to_cnt       <= '0;
        end else begin
            state        <= state_nx;
            render_begin <= (state_nx == CAM);
            cam_valid    <= (state_nx == CAM);
            feeder_begin <= (state_nx == FEED);
            fb_swap      <= (state_nx == SWAP);

            if (state == CAM) begin
                ang_x <= ang_x + ANGLE_W'(rot_en[0]);
                ang_y <= ang_y + ANGLE_W'(rot_en[1]);
                ang_z <= ang_z + ANGLE_W'(rot_en[2]);
            end

            if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
            else                 settle_cnt <= '0;

            if (state == FEED)                          grace_cnt <= GR_W'(BUSY_GRACE);
            else if (state == DRAIN && grace_cnt != '0) grace_cnt <= grace_cnt - 1'b1;

            if (state != DRAIN)                    to_cnt <= '0;
            else if (to_cnt != TO_W'(TIMEOUT))     to_cnt <= to_cnt + 1'b1;

            if (forced) timeout_flag <= 1'b1;
        end
    end

`ifdef FRAME_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_done    <= '0;
            frames_dropped <= '0;
        end else begin
            if (state_nx == SWAP && state == DRAIN && frames_done != '1)
                frames_done <= frames_done + 1'b1;
            if (frame_start && !accept && frames_dropped != '1)
                frames_dropped <= frames_dropped + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer (SINCOS_LAT=2, BUSY_GRACE=4, TIMEOUT=100).
module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [2:0] rot_en = 3'b000;
    logic       feeder_busy = 1'b0;
    logic       renderer_busy = 1'b0;
    logic       render_begin, cam_valid, feeder_begin, fb_swap, seq_busy, timeout_flag;
    logic [7:0] ang_x, ang_y, ang_z;
`ifdef FRAME_SEQ_STATS_EN
    logic [15:0] frames_done, frames_dropped;
`endif

    int checks = 0;
    int errors = 0;
    int swaps;
    int cams;

    frame_sequencer #(
        .ANGLE_W   (8),
        .SINCOS_LAT(2),
        .BUSY_GRACE(4),
        .TIMEOUT   (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .rot_en       (rot_en),
        .feeder_busy  (feeder_busy),
        .renderer_busy(renderer_busy),
        .render_begin (render_begin),
        .cam_valid    (cam_valid),
        .feeder_begin (feeder_begin),
        .fb_swap      (fb_swap),
        .ang_x        (ang_x),
        .ang_y        (ang_y),
        .ang_z        (ang_z),
        .seq_busy     (seq_busy),
        .timeout_flag (timeout_flag)
`ifdef FRAME_SEQ_STATS_EN
        ,
        .frames_done   (frames_done),
        .frames_dropped(frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (seq_busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(seq_busy), 32'd0);
    endtask

    task automatic run_frame(input logic [2:0] rot);
        rot_en      = rot;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_idle("frame_end");
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_outs", {28'd0, render_begin, cam_valid, feeder_begin, fb_swap}, 32'd0);
        chk("rst_ang", {8'd0, ang_z, ang_y, ang_x}, 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // accept latency and per-axis angle step
        rot_en      = 3'b001;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("cam_p1", 32'(cam_valid), 32'd1);
        chk("rbeg_p1", 32'(render_begin), 32'd1);
        chk("busy_p1", 32'(seq_busy), 32'd1);
        chk("feed_p1", 32'(feeder_begin), 32'd0);
        tick();
        chk("cam_p2", 32'(cam_valid), 32'd0);
        chk("angx_p2", 32'(ang_x), 32'd1);
        chk("angyz_p2", {16'd0, ang_z, ang_y}, 32'd0);
        tick();
        chk("feed_p3", 32'(feeder_begin), 32'd0);
        tick();
        chk("feed_p4", 32'(feeder_begin), 32'd1);

        // busy held through drain, with a dropped frame_start mid-drain
        feeder_busy = 1'b1;
        swaps = 0;
        cams  = 0;
        for (int i = 1; i <= 50; i++) begin
            if (i == 10) frame_start = 1'b1;
            if (i == 11) frame_start = 1'b0;
            tick();
            swaps += int'(fb_swap);
            cams  += int'(cam_valid);
        end
        chk("no_swap_busy", 32'(swaps), 32'd0);
        chk("no_cam_drop", 32'(cams), 32'd0);
        feeder_busy = 1'b0;
        tick();
        chk("swap_after_busy", 32'(fb_swap), 32'd1);
        chk("tflag_normal", 32'(timeout_flag), 32'd0);
`ifdef FRAME_SEQ_STATS_EN
        chk("dropped_1", 32'(frames_dropped), 32'd1);
`endif
        tick();
        chk("swap_1cyc", 32'(fb_swap), 32'd0);
        chk("idle_after_swap", 32'(seq_busy), 32'd0);
`ifdef FRAME_SEQ_STATS_EN
        chk("done_1", 32'(frames_done), 32'd1);
`endif
        swaps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            swaps += int'(fb_swap);
        end
        chk("swap_once", 32'(swaps), 32'd0);

        // frame_start in IDLE while renderer busy is dropped
        renderer_busy = 1'b1;
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
        renderer_busy = 1'b0;
        chk("idle_busy_drop_cam", 32'(cam_valid), 32'd0);
        chk("idle_busy_drop_st", 32'(seq_busy), 32'd0);
`ifdef FRAME_SEQ_STATS_EN
        chk("dropped_2", 32'(frames_dropped), 32'd2);
`endif

        // asynchronous reset in the middle of DRAIN
        rot_en      = 3'b000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        tick();
        chk("feed_r", 32'(feeder_begin), 32'd1);
        feeder_busy = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("drain_busy", 32'(seq_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(seq_busy), 32'd0);
        chk("arst_outs", {28'd0, render_begin, cam_valid, feeder_begin, fb_swap}, 32'd0);
        chk("arst_ang", {8'd0, ang_z, ang_y, ang_x}, 32'd0);
`ifdef FRAME_SEQ_STATS_EN
        chk("arst_stats", {frames_done, frames_dropped}, 32'd0);
`endif
        tick();
        rst_n       = 1'b1;
        feeder_busy = 1'b0;
        swaps = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            swaps += int'(fb_swap);
        end
        chk("arst_no_swap", 32'(swaps), 32'd0);
        chk("arst_idle", 32'(seq_busy), 32'd0);

        // angle wrap: 255 steps on x and y, z held
        for (int f = 0; f < 255; f++) run_frame(3'b011);
        chk("ang_x_255", 32'(ang_x), 32'd255);
        chk("ang_y_255", 32'(ang_y), 32'd255);
        chk("ang_z_hold", 32'(ang_z), 32'd0);
        run_frame(3'b001);
        chk("ang_x_wrap", 32'(ang_x), 32'd0);
        chk("ang_y_hold", 32'(ang_y), 32'd255);

        // renderer stuck busy forces a swap after 100 DRAIN cycles
        rot_en      = 3'b000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        tick();
        chk("feed_t", 32'(feeder_begin), 32'd1);
        renderer_busy = 1'b1;
        swaps = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            swaps += int'(fb_swap);
        end
        chk("to_no_early_swap", 32'(swaps), 32'd0);
        chk("to_flag_early", 32'(timeout_flag), 32'd0);
        tick();
        chk("to_swap", 32'(fb_swap), 32'd1);
        chk("to_flag", 32'(timeout_flag), 32'd1);
        tick();
        chk("to_idle", 32'(seq_busy), 32'd0);
        renderer_busy = 1'b0;
        run_frame(3'b000);
        chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
`ifdef FRAME_SEQ_STATS_EN
        chk("done_total", 32'(frames_done), 32'd258);
        chk("dropped_total", 32'(frames_dropped), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
